// File: rtl/if_id_skid.sv
// if_id_skid: IF->ID pipeline register with a one-entry skid buffer.
//
// Two entries: "main" drives out_*, "skid" catches a beat that was accepted
// while decode stalled. in_ready is a flop, so there is no combinational path
// from out_ready back to fetch. Strict FIFO order. Flush empties both entries
// and NOPs the instructions; out_pc keeps its last value.
//
// Parameters: PC_W, INST_W, IMM_W (< INST_W), CNT_W (perf counter width)
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_pc, in_inst    : fetch side
//   flush                                : drop held and incoming entries
//   out_valid/out_ready, out_pc,
//   out_inst, out_imm                    : decode side (all registered)
//   stall_cnt, bubble_cnt                : only with IF_ID_SKID_PERF_EN
//
// Build option: define IF_ID_SKID_PERF_EN to add saturating stall/bubble
// counters.
module if_id_skid #(
  parameter int PC_W   = 10,
  parameter int INST_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [INST_W-1:0] out_imm
`ifdef IF_ID_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic [INST_W-1:0] in_imm, skid_imm;
  logic              accept, pop;

  assign in_imm   = {{(INST_W-IMM_W){1'b0}}, in_inst[IMM_W-1:0]};
  assign skid_imm = {{(INST_W-IMM_W){1'b0}}, skid_inst[IMM_W-1:0]};

  // in_ready is itself a flop and doubles as the "skid empty" flag, so an
  // accept can only ever target an empty slot.
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
      out_imm    <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      // out_pc and skid_pc intentionally keep their values
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_imm    <= '0;
      skid_valid <= 1'b0;
      skid_inst  <= '0;
      in_ready   <= 1'b1;
    end else if (!out_valid || pop) begin
      // main is free this edge: refill from skid first to keep order
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_pc     <= skid_pc;
        out_inst   <= skid_inst;
        out_imm    <= skid_imm;
        skid_valid <= 1'b0;
        skid_inst  <= '0;
        in_ready   <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_inst  <= in_inst;
        out_imm   <= in_imm;
      end else begin
        // going empty: instruction reads as NOP, pc is retained
        out_valid <= 1'b0;
        out_inst  <= '0;
        out_imm   <= '0;
      end
    end else if (accept) begin
      // main held by a stalled decode: park the beat in skid
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_inst  <= in_inst;
      in_ready   <= 1'b0;
    end
  end

`ifdef IF_ID_SKID_PERF_EN
  // Saturating counters; only rst clears them, flush has no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && out_ready && bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  // Keeps CNT_W referenced in builds without counters.
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: scenario tasks plus a scoreboard monitor for if_id_skid.
// The monitor keeps a queue of accepted beats (occupancy 0..2) and checks
// out_valid, in_ready and the head entry on every falling edge.
module tb_if_id_skid;
  localparam int PC_W = 10, INST_W = 32, IMM_W = 16, CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [INST_W-1:0] in_inst, out_inst, out_imm;
`ifdef IF_ID_SKID_PERF_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  if_id_skid #(.PC_W(PC_W), .INST_W(INST_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_imm(out_imm)
`ifdef IF_ID_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(posedge rst) q.delete();

  // Scoreboard: inputs change at posedge+1, so negedge sees what the next
  // posedge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      int   sz;
      ent_t e;
      sz = q.size();
      total++;
      if (out_valid !== (sz != 0)) begin
        bad++;
        $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, sz != 0);
      end
      total++;
      if (in_ready !== (sz < 2)) begin
        bad++;
        $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, sz < 2);
      end
      total++;
      if (sz == 0) begin
        if (out_inst !== '0) begin
          bad++;
          $display("FAIL sb_empty_inst t=%0t got=%h exp=0", $time, out_inst);
        end
      end else begin
        e = q[0];
        if (out_pc !== e.pc || out_inst !== e.inst ||
            out_imm !== {16'h0, e.inst[15:0]}) begin
          bad++;
          $display("FAIL sb_head t=%0t got pc=%h inst=%h imm=%h exp pc=%h inst=%h",
                   $time, out_pc, out_inst, out_imm, e.pc, e.inst);
        end
      end
      if (flush) q.delete();
      else begin
        if (sz != 0 && out_ready) void'(q.pop_front());
        if (in_valid && sz < 2) begin
          e.pc = in_pc; e.inst = in_inst;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    flush = 1'b0; out_ready = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== '0) begin bad++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
    total++; if (out_inst !== '0) begin bad++; $display("FAIL rst_out_inst got=%h exp=0", out_inst); end
    total++; if (out_imm !== '0) begin bad++; $display("FAIL rst_out_imm got=%h exp=0", out_imm); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = PC_W'(i); in_inst = 32'hA + 32'(i);
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== PC_W'(i) || out_inst !== 32'hA + 32'(i) || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h rdy=%b exp v=1 pc=%h inst=%h rdy=1",
                 i, out_valid, out_pc, out_inst, in_ready, i, 32'hA + 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || out_inst !== '0) begin
      bad++; $display("FAIL stream_drain got v=%b inst=%h exp v=0 inst=0", out_valid, out_inst);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 10'd4; in_inst = 32'h400;
    step();
    total++; if (out_pc !== 10'd4) begin bad++; $display("FAIL stall_load got=%h exp=4", out_pc); end
    out_ready = 1'b0; in_pc = 10'd5; in_inst = 32'h500;
    step();
    total++;
    if (in_ready !== 1'b0 || out_pc !== 10'd4) begin
      bad++; $display("FAIL stall_skid got rdy=%b pc=%h exp rdy=0 pc=4", in_ready, out_pc);
    end
    in_pc = 10'd6; in_inst = 32'h600;  // must be ignored: in_ready is low
    step();
    total++;
    if (in_ready !== 1'b0 || out_pc !== 10'd4 || out_inst !== 32'h400) begin
      bad++; $display("FAIL stall_hold got rdy=%b pc=%h inst=%h exp rdy=0 pc=4 inst=400", in_ready, out_pc, out_inst);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++;
    if (out_pc !== 10'd5 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release got pc=%h v=%b rdy=%b exp pc=5 v=1 rdy=1", out_pc, out_valid, in_ready);
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 10'h10; in_inst = 32'h1000;
    step();
    in_pc = 10'h11; in_inst = 32'h1100;
    step();
    in_pc = 10'd7; in_inst = 32'h777; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_inst !== '0 || in_ready !== 1'b1 || out_pc !== 10'h10) begin
      bad++; $display("FAIL flush_state got v=%b inst=%h rdy=%b pc=%h exp v=0 inst=0 rdy=1 pc=10",
                      out_valid, out_inst, in_ready, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || out_pc === 10'd7) begin
        bad++; $display("FAIL flush_after_%0d got v=%b pc=%h exp v=0", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_imm();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 10'h30; in_inst = 32'h1234ABCD;
    step();
    in_valid = 1'b0;
    total++;
    if (out_imm !== 32'h0000ABCD || out_inst !== 32'h1234ABCD) begin
      bad++; $display("FAIL imm got imm=%h inst=%h exp imm=0000abcd inst=1234abcd", out_imm, out_inst);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 10'h20; in_inst = 32'h2000;
    step();
    in_pc = 10'h21; in_inst = 32'h2100;
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_full got rdy=%b exp=0", in_ready); end
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== '0) begin
      bad++; $display("FAIL arst_immediate got v=%b rdy=%b inst=%h exp v=0 rdy=1 inst=0", out_valid, in_ready, out_inst);
    end
    #1 rst = 1'b0;
    in_valid = 1'b1; in_pc = 10'h22; in_inst = 32'h2200;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_pc !== 10'h22) begin
      bad++; $display("FAIL arst_first_accept got v=%b pc=%h exp v=1 pc=22", out_valid, out_pc);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_pc     = PC_W'($urandom);
      in_inst   = $urandom;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    total++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL b2b_drain got v=%b left=%0d exp v=0 left=0", out_valid, q.size());
    end
  endtask

`ifdef IF_ID_SKID_PERF_EN
  task automatic test_counters();
    rst = 1'b1; #2 rst = 1'b0;
    total++;
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      bad++; $display("FAIL cnt_reset got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt);
    end
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 10'h40; in_inst = 32'h4000;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    total++;
    if (stall_cnt !== 4'd15 || bubble_cnt !== 4'd0) begin
      bad++; $display("FAIL cnt_stall_sat got s=%0d b=%0d exp s=15 b=0", stall_cnt, bubble_cnt);
    end
    out_ready = 1'b1;
    repeat (4) step();
    total++;
    if (stall_cnt !== 4'd15 || bubble_cnt !== 4'd3) begin
      bad++; $display("FAIL cnt_bubble got s=%0d b=%0d exp s=15 b=3", stall_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_imm();
    test_async_reset();
    test_back_to_back();
`ifdef IF_ID_SKID_PERF_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
